// File: rtl/any1_vagen.sv
// any1_vagen: vector address sequencer.
// Walks the elements of one vector memory op (single, unit-stride, strided
// or indexed), skips masked-off elements and streams one effective address
// per active element over a valid/ready handshake.
// Optional feature macro: ANY1_VAGEN_ALIGN_CHECK_EN (misaligned-address fault).
module any1_vagen #(
    parameter int AWID  = 32,
    parameter int VLMAX = 64,
    parameter int SCW   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [1:0]                 esize,
    input  logic [SCW-1:0]             sc,
    input  logic [AWID-1:0]            base,
    input  logic [AWID-1:0]            imm,
    input  logic [AWID-1:0]            stride,
    input  logic [$clog2(VLMAX):0]     vl,
    input  logic [VLMAX-1:0]           mask,
    input  logic [AWID-1:0]            idx,
    input  logic                       idx_valid,
    output logic                       idx_ready,
    output logic                       busy,
    output logic [AWID-1:0]            ea,
    output logic [$clog2(VLMAX)-1:0]   ea_step,
    output logic                       ea_valid,
    input  logic                       ea_ready,
    output logic                       ea_last,
    output logic                       done,
    output logic                       fault
);

    localparam int STW = $clog2(VLMAX);
    localparam int VLW = STW + 1;

    localparam logic [1:0] M_SINGLE = 2'd0;
    localparam logic [1:0] M_UNIT   = 2'd1;
    localparam logic [1:0] M_STRIDE = 2'd2;
    localparam logic [1:0] M_INDEX  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Latched operands
    logic [1:0]       r_mode;
    logic [1:0]       r_esize;
    logic [SCW-1:0]   r_sc;
    logic [AWID-1:0]  r_bi;
    logic [AWID-1:0]  r_stride;
    logic [VLW-1:0]   r_vl;
    logic [VLMAX-1:0] r_mask;

    // Sequencer state
    state_t           r_state;
    logic [STW-1:0]   r_step;

    // Output registers
    logic             r_idx_ready;
    logic             r_busy;
    logic [AWID-1:0]  r_ea;
    logic [STW-1:0]   r_ea_step;
    logic             r_ea_valid;
    logic             r_ea_last;
    logic             r_done;
    logic             r_fault;

    // Combinational helpers
    logic [VLMAX-1:0] w_mask_ld;
    logic [VLW-1:0]   w_vl_ld;
    logic [AWID-1:0]  w_off;
    logic [AWID-1:0]  w_addr;
    logic [VLMAX-1:0] w_above;
    logic             w_last;
    logic             w_misalign;
    logic             w_active;
    logic             w_at_end;
    logic [STW-1:0]   w_step_inc;
    state_t           w_state_n;
    logic [STW-1:0]   w_step_n;
    logic             w_load;
    logic             w_idxm_nx;
    logic [VLMAX-1:0] w_mask_nx;
    logic             w_idx_ready_n;

    // Operand shaping at launch: single mode is one unconditional element,
    // otherwise mask bits at or beyond vl are dropped so the scan only sees
    // elements that really exist.
    always_comb begin
        w_mask_ld = '0;
        w_vl_ld   = vl;
        if (mode == M_SINGLE) begin
            w_vl_ld      = VLW'(1);
            w_mask_ld[0] = 1'b1;
        end else begin
            for (int i = 0; i < VLMAX; i++) begin
                w_mask_ld[i] = mask[i] && (VLW'(i) < vl);
            end
        end
    end

    // Address of the current step, last-element detection and alignment test
    always_comb begin
        w_off = '0;
        case (r_mode)
            M_SINGLE: w_off = '0;
            M_UNIT:   w_off = AWID'(r_step) << r_esize;
            M_STRIDE: w_off = r_stride * AWID'(r_step);
            M_INDEX:  w_off = idx << r_sc;
            default:  w_off = '0;
        endcase
        w_addr = r_bi + w_off;

        w_above = '0;
        for (int i = 0; i < VLMAX; i++) begin
            w_above[i] = r_mask[i] && (STW'(i) > r_step);
        end
        w_last = ~|w_above;

`ifdef ANY1_VAGEN_ALIGN_CHECK_EN
        w_misalign = |(w_addr & ((AWID'(1) << r_esize) - AWID'(1)));
`else
        w_misalign = 1'b0;
`endif

        w_active   = r_mask[r_step];
        w_step_inc = r_step + STW'(1);
        w_at_end   = ({1'b0, r_step} + VLW'(1)) >= r_vl;
    end

    // Next-state logic: scan, emit, wait for handshake, finish
    always_comb begin
        w_state_n = r_state;
        w_step_n  = r_step;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_GEN;
                    w_step_n  = '0;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_GEN: begin
                if (!w_active) begin
                    if (w_at_end) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_step_n = w_step_inc;
                    end
                end else if ((r_mode != M_INDEX) || idx_valid) begin
                    w_load    = 1'b1;
                    w_state_n = S_OUT;
                end else begin
                    w_state_n = S_GEN;
                end
            end
            S_OUT: begin
                if (ea_ready) begin
                    if (r_ea_last) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_step_n  = w_step_inc;
                        w_state_n = S_GEN;
                    end
                end else begin
                    w_state_n = S_OUT;
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // idx_ready is registered, so it is derived from where the sequencer
    // will be next cycle (using the incoming operands while idle)
    always_comb begin
        if (r_state == S_IDLE) begin
            w_idxm_nx = (mode == M_INDEX);
            w_mask_nx = w_mask_ld;
        end else begin
            w_idxm_nx = (r_mode == M_INDEX);
            w_mask_nx = r_mask;
        end
        w_idx_ready_n = (w_state_n == S_GEN) && w_idxm_nx && w_mask_nx[w_step_n];
    end

    // Operand capture on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= 2'd0;
            r_esize  <= 2'd0;
            r_sc     <= '0;
            r_bi     <= '0;
            r_stride <= '0;
            r_vl     <= '0;
            r_mask   <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_mode   <= mode;
            r_esize  <= esize;
            r_sc     <= sc;
            r_bi     <= base + imm;
            r_stride <= stride;
            r_vl     <= w_vl_ld;
            r_mask   <= w_mask_ld;
        end else begin
            r_mode   <= r_mode;
            r_esize  <= r_esize;
            r_sc     <= r_sc;
            r_bi     <= r_bi;
            r_stride <= r_stride;
            r_vl     <= r_vl;
            r_mask   <= r_mask;
        end
    end

    // State, step and handshake/status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ea_valid  <= 1'b0;
            r_idx_ready <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_step      <= w_step_n;
            r_busy      <= (w_state_n == S_GEN) || (w_state_n == S_OUT);
            r_done      <= (w_state_n == S_DONE);
            r_ea_valid  <= (w_state_n == S_OUT);
            r_idx_ready <= w_idx_ready_n;
        end
    end

    // Output address register; a fault forces the element to be the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ea      <= '0;
            r_ea_step <= '0;
            r_ea_last <= 1'b0;
            r_fault   <= 1'b0;
        end else if (w_load) begin
            r_ea      <= w_addr;
            r_ea_step <= r_step;
            r_ea_last <= w_last || w_misalign;
            r_fault   <= w_misalign;
        end else if (w_state_n == S_DONE) begin
            r_fault   <= 1'b0;
        end else begin
            r_ea      <= r_ea;
            r_ea_step <= r_ea_step;
            r_ea_last <= r_ea_last;
            r_fault   <= r_fault;
        end
    end

    assign idx_ready = r_idx_ready;
    assign busy      = r_busy;
    assign ea        = r_ea;
    assign ea_step   = r_ea_step;
    assign ea_valid  = r_ea_valid;
    assign ea_last   = r_ea_last;
    assign done      = r_done;
    assign fault     = r_fault;

endmodule

// File: tb/tb_any1_vagen.sv
// Testbench for any1_vagen: directed vector table, hand-written corner
// sequences and randomized ops checked against a behavioural model.
`timescale 1ns/1ps
module tb_any1_vagen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  esize;
    logic [2:0]  sc;
    logic [31:0] base, imm, stride;
    logic [6:0]  vl;
    logic [63:0] mask;
    logic [31:0] idx;
    logic        idx_valid;
    logic        idx_ready;
    logic        busy;
    logic [31:0] ea;
    logic [5:0]  ea_step;
    logic        ea_valid;
    logic        ea_ready;
    logic        ea_last;
    logic        done;
    logic        fault;

    always #5 clk = ~clk;

    any1_vagen #(.AWID(32), .VLMAX(64), .SCW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .esize(esize), .sc(sc),
        .base(base), .imm(imm), .stride(stride), .vl(vl), .mask(mask),
        .idx(idx), .idx_valid(idx_valid), .idx_ready(idx_ready), .busy(busy),
        .ea(ea), .ea_step(ea_step), .ea_valid(ea_valid), .ea_ready(ea_ready),
        .ea_last(ea_last), .done(done), .fault(fault)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [1:0]  esize;
        logic [2:0]  sc;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] stride;
        logic [6:0]  vl;
        logic [63:0] mask;
    } op_t;

    typedef struct packed {
        op_t              op;
        logic [31:0]      i0;
        logic [31:0]      i1;
        int               dly;
        int               n;
        logic [3:0][31:0] e;
        logic [3:0][7:0]  s;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] idx_list [64];
    logic [31:0] exp_ea[$];
    int          exp_step[$];
    logic        exp_last[$];
    logic        exp_fault[$];
    int          exp_idx_used;
    logic [31:0] got_ea[$];
    int          got_step[$];
    logic        got_last[$];
    logic        got_fault[$];
    int          first_valid, last_emit, done_cyc, kidx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk elements 0..vl-1, every active one yields an address.
    task automatic model(input op_t o);
        int n;
        int k;
        logic [31:0] a;
        logic mis;
        exp_ea.delete(); exp_step.delete(); exp_last.delete(); exp_fault.delete();
        n = (o.mode == 2'd0) ? 1 : int'(o.vl);
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (o.mode == 2'd0 || o.mask[i]) begin
                case (o.mode)
                    2'd0:    a = o.base + o.imm;
                    2'd1:    a = o.base + o.imm + i * (1 << o.esize);
                    2'd2:    a = o.base + o.imm + i * o.stride;
                    default: a = o.base + o.imm + idx_list[k] * (1 << o.sc);
                endcase
                k++;
                mis = 1'b0;
`ifdef ANY1_VAGEN_ALIGN_CHECK_EN
                mis = (a % (32'd1 << o.esize)) != 32'd0;
`endif
                exp_ea.push_back(a);
                exp_step.push_back(i);
                exp_last.push_back(1'b0);
                exp_fault.push_back(mis);
                if (mis) break;
            end
        end
        if (exp_last.size() > 0) exp_last[exp_last.size()-1] = 1'b1;
        exp_idx_used = (o.mode == 2'd3) ? exp_ea.size() : 0;
    endtask

    // Launch one op, drive handshakes, collect the stream and compare to the model.
    // rdy_mode: 0 always ready, 1 random, 2 hold off 5 cycles on step 1.
    // idx_dly: cycles idx_valid lags idx_ready (negative = random per element).
    task automatic run_op(input op_t o, input int rdy_mode, input int idx_dly, input bit poke);
        int done_cnt, idx_wait, cur_dly, bp_cnt;
        bit prev_stall, pidx_wait, finished;
        logic [31:0] pea;
        logic [5:0]  pstep;
        logic        plast;
        model(o);
        got_ea.delete(); got_step.delete(); got_last.delete(); got_fault.delete();
        done_cnt = 0; kidx = 0; first_valid = -1; last_emit = -1; done_cyc = -1;
        idx_wait = 0; bp_cnt = 0; finished = 1'b0;
        prev_stall = 1'b0; pidx_wait = 1'b0; pea = 32'd0; pstep = 6'd0; plast = 1'b0;
        cur_dly = (idx_dly < 0) ? $urandom_range(0, 3) : idx_dly;
        @(posedge clk); #1;
        start = 1'b1; mode = o.mode; esize = o.esize; sc = o.sc; base = o.base;
        imm = o.imm; stride = o.stride; vl = o.vl; mask = o.mask;
        ea_ready = 1'b1; idx = idx_list[0]; idx_valid = (cur_dly == 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", ea_valid, 1);
                check("hold_ea", ea, pea);
                check("hold_step", ea_step, pstep);
                check("hold_last", ea_last, plast);
            end
            if (pidx_wait) check("idx_ready_hold", idx_ready, 1);
            if (ea_valid && first_valid < 0) first_valid = cyc;
            if (ea_valid && ea_ready) begin
                got_ea.push_back(ea); got_step.push_back(int'(ea_step));
                got_last.push_back(ea_last); got_fault.push_back(fault);
                last_emit = cyc;
            end
            prev_stall = ea_valid && !ea_ready;
            pea = ea; pstep = ea_step; plast = ea_last;
            pidx_wait = idx_ready && !idx_valid;
            if (idx_ready && idx_valid) begin
                kidx++; idx_wait = 0;
                if (idx_dly < 0) cur_dly = $urandom_range(0, 3);
            end else if (idx_ready) begin
                idx_wait++;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (poke && busy) begin
                start = 1'b1; mode = 2'($urandom); esize = 2'($urandom); sc = 3'($urandom);
                base = $urandom; imm = $urandom; stride = $urandom;
                vl = 7'($urandom_range(0, 64)); mask = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            idx = idx_list[kidx % 64];
            idx_valid = (idx_wait >= cur_dly);
            case (rdy_mode)
                0: ea_ready = 1'b1;
                1: ea_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (ea_valid && ea_step == 6'd1 && bp_cnt < 5) begin
                        ea_ready = 1'b0; bp_cnt++;
                    end else begin
                        ea_ready = 1'b1;
                    end
                end
            endcase
        end
        start = 1'b0;
        check("op_finished", finished, 1);
        check("n_elems", got_ea.size(), exp_ea.size());
        for (int i = 0; i < exp_ea.size() && i < got_ea.size(); i++) begin
            check("ea", got_ea[i], exp_ea[i]);
            check("ea_step", got_step[i], exp_step[i]);
            check("ea_last", got_last[i], exp_last[i]);
            check("fault", got_fault[i], exp_fault[i]);
        end
        check("done_count", done_cnt, 1);
        check("idx_consumed", kidx, exp_idx_used);
        check("idle_after", {busy, ea_valid, fault, idx_ready}, 0);
    endtask

    function automatic vec_t mkv(
        input logic [1:0] md, input logic [1:0] es, input logic [2:0] sc_,
        input logic [31:0] b, input logic [31:0] im, input logic [31:0] st,
        input logic [6:0] vl_, input logic [63:0] mk, input logic [31:0] i0,
        input logic [31:0] i1, input int dly, input int n,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
        input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
        vec_t v;
        v.op.mode = md; v.op.esize = es; v.op.sc = sc_; v.op.base = b; v.op.imm = im;
        v.op.stride = st; v.op.vl = vl_; v.op.mask = mk; v.i0 = i0; v.i1 = i1;
        v.dly = dly; v.n = n;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        return v;
    endfunction

    vec_t vecs [9];

    initial begin
        op_t o;
        bit  seen, dseen;
        rst = 1'b1; start = 1'b0; mode = 2'd0; esize = 2'd0; sc = 3'd0;
        base = 32'd0; imm = 32'd0; stride = 32'd0; vl = 7'd0; mask = 64'd0;
        idx = 32'd0; idx_valid = 1'b0; ea_ready = 1'b0;
        for (int i = 0; i < 64; i++) idx_list[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ea, ea_step, ea_valid, ea_last, done, busy, idx_ready, fault}, 64'd0);
        rst = 1'b0;

        //               md    es    sc    base          imm         stride        vl     mask         i0     i1     dly n  e0..e3                                            s0..s3
        vecs[0] = mkv(2'd1, 2'd2, 3'd0, 32'h1000,     32'h10, 32'h0,        7'd4,  64'hF,    32'd0, 32'd0, 0, 4, 32'h1010, 32'h1014, 32'h1018, 32'h101C,        8'd0, 8'd1, 8'd2, 8'd3);
        vecs[1] = mkv(2'd2, 2'd3, 3'd0, 32'h2000,     32'h0,  32'hFFFFFFF8, 7'd3,  64'h5,    32'd0, 32'd0, 0, 2, 32'h2000, 32'h1FF0, 32'h0, 32'h0,             8'd0, 8'd2, 8'd0, 8'd0);
        vecs[2] = mkv(2'd3, 2'd3, 3'd3, 32'h100,      32'h0,  32'h0,        7'd2,  64'h3,    32'd5, 32'd1, 3, 2, 32'h128, 32'h108, 32'h0, 32'h0,               8'd0, 8'd1, 8'd0, 8'd0);
        vecs[3] = mkv(2'd0, 2'd2, 3'd0, 32'h3000,     32'h4,  32'h0,        7'd7,  64'h0,    32'd0, 32'd0, 0, 1, 32'h3004, 32'h0, 32'h0, 32'h0,                8'd0, 8'd0, 8'd0, 8'd0);
        vecs[4] = mkv(2'd1, 2'd2, 3'd0, 32'h1000,     32'h0,  32'h0,        7'd0,  64'hF,    32'd0, 32'd0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0,                   8'd0, 8'd0, 8'd0, 8'd0);
        vecs[5] = mkv(2'd1, 2'd2, 3'd0, 32'h1000,     32'h0,  32'h0,        7'd8,  64'h0,    32'd0, 32'd0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0,                   8'd0, 8'd0, 8'd0, 8'd0);
        vecs[6] = mkv(2'd1, 2'd0, 3'd0, 32'hFFFFFFFE, 32'h0,  32'h0,        7'd4,  64'hA,    32'd0, 32'd0, 0, 2, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,            8'd1, 8'd3, 8'd0, 8'd0);
        vecs[7] = mkv(2'd1, 2'd1, 3'd0, 32'h40,       32'h0,  32'h0,        7'd2,  64'hF1,   32'd0, 32'd0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0,                  8'd0, 8'd0, 8'd0, 8'd0);
        vecs[8] = mkv(2'd1, 2'd0, 3'd0, 32'h0,        32'h0,  32'h0,        7'd64, 64'h8000000000000000, 32'd0, 32'd0, 0, 1, 32'h3F, 32'h0, 32'h0, 32'h0, 8'd63, 8'd0, 8'd0, 8'd0);

        for (int vi = 0; vi < 9; vi++) begin
            idx_list[0] = vecs[vi].i0;
            idx_list[1] = vecs[vi].i1;
            run_op(vecs[vi].op, 0, vecs[vi].dly, 1'b0);
            check("vec_n", got_ea.size(), vecs[vi].n);
            for (int j = 0; j < vecs[vi].n && j < got_ea.size(); j++) begin
                check("vec_ea", got_ea[j], vecs[vi].e[j]);
                check("vec_step", got_step[j], vecs[vi].s[j]);
                check("vec_last", got_last[j], (j == vecs[vi].n - 1));
            end
            if (vi == 0) begin
                check("first_latency", first_valid, 2);
                check("last_emit_cycle", last_emit, 8);
                check("done_cycle", done_cyc, 9);
            end
            if (vecs[vi].n == 0) check("no_valid_seen", first_valid, -1);
        end

        // Backpressure on step 1 with start pulses and junk operands while busy
        o = vecs[0].op;
        run_op(o, 2, 0, 1'b1);
        check("bp_n", got_ea.size(), 4);
        if (got_ea.size() > 1) check("bp_ea1", got_ea[1], 32'h1014);

`ifdef ANY1_VAGEN_ALIGN_CHECK_EN
        // Misaligned element terminates the op
        o = vecs[0].op;
        o.imm = 32'h0; o.base = 32'h1002;
        run_op(o, 0, 0, 1'b0);
        check("align_n", got_ea.size(), 1);
        if (got_ea.size() > 0) begin
            check("align_ea", got_ea[0], 32'h1002);
            check("align_fault", got_fault[0], 1);
            check("align_last", got_last[0], 1);
        end
`endif

        // Randomized ops against the model
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 64; i++) idx_list[i] = $urandom;
            o.mode = 2'($urandom); o.esize = 2'($urandom); o.sc = 3'($urandom);
            o.base = $urandom; o.imm = $urandom; o.stride = $urandom;
            if (r % 2 == 0) begin
                o.base = o.base & 32'hFFFFFFF8; o.imm = o.imm & 32'hFFFFFFF8;
                o.stride = o.stride & 32'hFFFFFFF8; o.sc = 3'd3;
            end
            o.vl = 7'($urandom_range(0, 64));
            if ($urandom_range(0, 1) == 0) o.mask = {$urandom, $urandom};
            else o.mask = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            run_op(o, 1, -1, ($urandom_range(0, 1) == 1));
        end

        // Reset in the middle of an op holding step 2
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd1; esize = 2'd2; base = 32'h5000; imm = 32'h0;
        vl = 7'd8; mask = 64'hFF; ea_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (ea_valid && ea_step == 6'd2) begin
                ea_ready = 1'b0;
                seen = 1'b1;
                break;
            end
        end
        check("rst_reach_step2", seen, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ea_ready = 1'b1;
        check("rst_midop_outputs", {ea, ea_step, ea_valid, ea_last, done, busy, idx_ready, fault}, 64'd0);
        dseen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || ea_valid || busy) dseen = 1'b1;
        end
        check("rst_no_done", dseen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/any1_vagen.md
Name: any1_vagen

Overview:
- Parametrised vector address sequencer; next generation of the single-shot scalar address generator.
- Accepts one vector memory op (unit-stride, strided, indexed, or single-element) and emits one effective address per active element over a valid/ready stream to the load/store unit.
- Honours a per-element mask and vector length.
- Sits between the issue/register-read stage and the memory request queue.

Parameters:
AWID, 32, address width in bits
VLMAX, 64, maximum elements per operation (power of 2)
SCW, 3, width of index scale shift field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  launch operation; accepted only when busy=0
mode  in  2  0=single, 1=unit stride, 2=strided, 3=indexed
esize  in  2  element size log2 (1,2,4,8 bytes)
sc  in  SCW  index left-shift amount (indexed mode)
base  in  AWID  ia value
imm  in  AWID  displacement
stride  in  AWID  signed byte stride (strided mode)
vl  in  $clog2(VLMAX)+1  element count, 0..VLMAX
mask  in  VLMAX  element enable bits, bit i = element i
idx  in  AWID  index value for current element (indexed mode)
idx_valid  in  1  idx is valid
idx_ready  out  1  sequencer consumes idx this cycle
busy  out  1  operation in progress
ea  out  AWID  effective address
ea_step  out  $clog2(VLMAX)  element number of ea
ea_valid  out  1  ea/ea_step valid
ea_ready  in  1  downstream accepts ea
ea_last  out  1  this is the final emitted element
done  out  1  one-cycle pulse at operation completion
fault  out  1  misaligned address detected (feature only; else tied 0)

Behaviour:
- Reset: state IDLE; ea, ea_step, ea_valid, ea_last, done, busy, idx_ready, fault = 0.
- Operands are latched on an accepted start. Inputs other than idx/idx_valid/ea_ready are ignored while busy.
- States:
  - IDLE: on start, latch operands, step=0, go to GEN, busy=1.
  - GEN: scan the current step. If mask[step]=0, advance step without emitting (one step per cycle). If mask[step]=1:
    - Non-indexed: load the output register with the address; go to OUT.
    - Indexed: assert idx_ready; when idx_valid=1, load the output register; go to OUT. An idx is consumed only for active elements.
  - OUT: ea_valid=1. ea/ea_step/ea_last are held stable until ea_ready=1. On handshake, if ea_last then go to DONE, else step+1 and go to GEN.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Address arithmetic, modulo 2^AWID (wrap is silent):
  - single: base+imm
  - unit: base+imm+(step<<esize)
  - strided: base+imm+step*stride (signed multiply, low AWID bits)
  - indexed: base+imm+(idx<<sc)
- ea_last=1 when no set mask bit exists at positions step+1..vl-1.
- vl=0, or no active elements below vl: no ea emitted; DONE reached after the mask scan completes; done pulses.
- mode=single forces vl=1 and ignores mask[0] (always emits).
- Latency: first ea_valid rises 2 cycles after start when mask[0]=1 (non-indexed, no stall). Back-to-back active elements: throughput of one ea per 2 cycles.
- start asserted while busy is ignored. start in the same cycle as a DONE pulse is ignored.
- rst mid-operation aborts immediately: no done pulse, all outputs return to reset values next cycle.

Optional Feature:
- Macro: ANY1_VAGEN_ALIGN_CHECK_EN.
- Enabled: when an address is loaded into the output register with ea[esize-1:0]!=0, fault=1 is presented with that ea (ea_valid=1). On handshake the operation terminates: ea_last is forced 1, then DONE. fault clears at done.
- Disabled: fault is tied 0; misaligned addresses are emitted normally.

Test Plan:
- Unit stride: base=0x1000, imm=0x10, esize=2, vl=4, mask=0xF, ea_ready=1 -> ea 0x1010, 0x1014, 0x1018, 0x101C; ea_step 0..3; ea_last on step 3; one done pulse.
- Strided negative: base=0x2000, imm=0, stride=-8, vl=3, mask=0b101 -> ea 0x2000 (step 0), 0x1FF0 (step 2, ea_last); step 1 skipped.
- Indexed with idx stall: sc=3, idx={5,1} delivered with idx_valid delayed 3 cycles, base=0x100, vl=2 -> ea 0x128 then 0x108; idx_ready held until each idx_valid.
- Backpressure: ea_ready=0 for 5 cycles on step 1 -> ea/ea_step unchanged; no element lost or duplicated; start pulses during busy are ignored.
- vl=0, or mask=0 with vl=8 -> no ea_valid; done pulses exactly once; busy deasserts.
- Reset mid-op at step 2 of vl=8 -> all outputs 0 next cycle, no done. With ANY1_VAGEN_ALIGN_CHECK_EN: esize=2, base=0x1002 -> fault=1 with ea 0x1002, ea_last=1, then done.
